// File: rtl/tile_map_renderer.sv
// Tile-map background renderer: scrolled screen position -> map cell -> texture ROM address -> colour.
// Four-clock fixed pipeline, one pixel per clock; the map lives in a run-time writable tile RAM.
module tile_map_renderer #(
  parameter int H_START     = 144,
  parameter int V_START     = 31,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int TILE_LOG2   = 5,
  parameter int TEX_LOG2    = 3,
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 15,
  parameter int TILE_BITS   = 2,
  parameter int ANIM_BASE   = 1,
  parameter int ANIM_W      = 4,
  parameter int BORDER_TILE = 1,
  parameter int COLOR_W     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [9:0]                          h_count,
  input  logic [9:0]                          v_count,
  input  logic                                anim_tick,
  input  logic [9:0]                          scroll_x,
  input  logic [9:0]                          scroll_y,
  input  logic                                clear_req,
  input  logic                                wr_en,
  input  logic [$clog2(MAP_W*MAP_H)-1:0]      wr_addr,
  input  logic [TILE_BITS-1:0]                wr_data,
  output logic                                wr_ready,
  output logic                                busy,
  output logic [TILE_BITS+2*TEX_LOG2-1:0]     tex_addr,
  input  logic [COLOR_W-1:0]                  tex_data,
  output logic [COLOR_W-1:0]                  color
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int AW    = $clog2(CELLS);
  localparam int TA_W  = TILE_BITS + 2 * TEX_LOG2;
  localparam int CW    = 12;
  localparam int RW    = $clog2(MAP_H);
  localparam int KW    = $clog2(MAP_W);

  localparam logic [CW-1:0] H_LO   = CW'(H_START);
  localparam logic [CW-1:0] H_HI   = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] V_LO   = CW'(V_START);
  localparam logic [CW-1:0] V_HI   = CW'(V_START + V_ACTIVE);
  localparam logic [CW-1:0] WRAP_X = CW'(MAP_W << TILE_LOG2);
  localparam logic [CW-1:0] WRAP_Y = CW'(MAP_H << TILE_LOG2);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;
  logic [RW-1:0]         clr_row_q, clr_row_d;
  logic [KW-1:0]         clr_col_q, clr_col_d;
  logic                  busy_q, busy_d;
  logic                  wr_ready_q, wr_ready_d;
  logic [9:0]            scroll_x_q, scroll_x_d;
  logic [9:0]            scroll_y_q, scroll_y_d;
  logic [ANIM_W-1:0]     anim_q, anim_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [TEX_LOG2-1:0]   tx_q, tx_d;
  logic [TEX_LOG2-1:0]   ty_q, ty_d;
  logic                  act1_q, act1_d;
  logic                  act2_q, act2_d;
  logic                  act3_q, act3_d;
  logic [TA_W-1:0]       tex_addr_q, tex_addr_d;
  logic [COLOR_W-1:0]    color_q, color_d;

  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [TILE_BITS-1:0]  mem_data;
  logic [TILE_BITS-1:0]  tile_mem [CELLS];

  logic [CW-1:0]         h_ext, v_ext, px_raw, py_raw, px, py;
  logic [TILE_BITS-1:0]  cur_type;
  logic                  flip;
  logic [TEX_LOG2-1:0]   tx_f;
  logic                  clr_edge;

  // Stage 1: screen position -> wrapped map position, cell index and texel.
  always_comb begin
    h_ext  = CW'(h_count);
    v_ext  = CW'(v_count);
    px_raw = h_ext - H_LO + CW'(scroll_x_q);
    py_raw = v_ext - V_LO + CW'(scroll_y_q);
    px     = (px_raw >= WRAP_X) ? px_raw - WRAP_X : px_raw;
    py     = (py_raw >= WRAP_Y) ? py_raw - WRAP_Y : py_raw;
    act1_d = (h_ext >= H_LO) && (h_ext < H_HI) && (v_ext >= V_LO) && (v_ext < V_HI);
    idx_d  = act1_d ? AW'(py >> TILE_LOG2) * AW'(MAP_W) + AW'(px >> TILE_LOG2) : '0;
    tx_d   = px[TEX_LOG2-1:0];
    ty_d   = py[TEX_LOG2-1:0];
  end

  // Stages 2-4: tile read and mirror, ROM round trip, colour gate.
  always_comb begin
    cur_type   = tile_mem[idx_q];
    flip       = (cur_type >= TILE_BITS'(ANIM_BASE)) && anim_q[ANIM_W-1];
    tx_f       = flip ? ~tx_q : tx_q;
    tex_addr_d = {cur_type, ty_q, tx_f};
    act2_d     = act1_q;
    act3_d     = act2_q;
    color_d    = (act3_q && state_q == S_RUN) ? tex_data : '0;
    anim_d     = anim_tick ? anim_q + 1'b1 : anim_q;
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (h_count == '0 && v_count == '0) begin
      scroll_x_d = scroll_x;
      scroll_y_d = scroll_y;
    end
  end

  // Map control: clear sweep owns the RAM write port; user writes only in RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    clr_edge   = (clr_row_q == '0) || (clr_row_q == RW'(MAP_H - 1)) ||
                 (clr_col_q == '0) || (clr_col_q == KW'(MAP_W - 1));
    case (state_q)
      S_CLEAR: begin
        if (clear_req) begin
          clr_addr_d = '0;
          clr_row_d  = '0;
          clr_col_d  = '0;
        end else begin
          mem_we   = 1'b1;
          mem_addr = clr_addr_q;
          mem_data = clr_edge ? TILE_BITS'(BORDER_TILE) : '0;
          if (clr_addr_q == AW'(CELLS - 1)) begin
            state_d    = S_RUN;
            clr_addr_d = '0;
            clr_row_d  = '0;
            clr_col_d  = '0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_col_q == KW'(MAP_W - 1)) begin
              clr_col_d = '0;
              clr_row_d = clr_row_q + 1'b1;
            end else begin
              clr_col_d = clr_col_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          clr_row_d  = '0;
          clr_col_d  = '0;
        end else if (wr_en && (32'(wr_addr) < CELLS)) begin
          mem_we   = 1'b1;
          mem_addr = wr_addr;
          mem_data = wr_data;
        end
      end
    endcase
    busy_d     = (state_d == S_CLEAR);
    wr_ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      anim_q     <= '0;
      idx_q      <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      act1_q     <= 1'b0;
      act2_q     <= 1'b0;
      act3_q     <= 1'b0;
      tex_addr_q <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      anim_q     <= anim_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      act1_q     <= act1_d;
      act2_q     <= act2_d;
      act3_q     <= act3_d;
      tex_addr_q <= tex_addr_d;
      color_q    <= color_d;
    end
  end

  // Map contents are not reset; the clear sweep re-initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) tile_mem[mem_addr] <= mem_data;
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign tex_addr = tex_addr_q;
  assign color    = color_q;

endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed bench for tile_map_renderer: pixel vector table plus hand sequences for clear, animation,
// scroll wrap, same-clock write/read and mid-sweep reset. The texture ROM is a small synchronous model.
module tb_tile_map_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count, scroll_x, scroll_y;
  logic       anim_tick, clear_req, wr_en;
  logic [8:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ready, busy;
  logic [7:0] tex_addr, tex_data, color;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    bit         chk_ta;
    logic [7:0] ta;
    logic [7:0] col;
    string      nm;
  } vec_t;

  vec_t vecs[12];

  tile_map_renderer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_count   (h_count),
    .v_count   (v_count),
    .anim_tick (anim_tick),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .tex_addr  (tex_addr),
    .tex_data  (tex_data),
    .color     (color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    if (a == 8'h80) return 8'hA5;
    return (a ^ 8'h3C) + 8'd1;
  endfunction

  always @(posedge clk) tex_data <= rom_f(tex_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One-clock pixel, then idle; tex_addr checked after 2 edges, colour after 4.
  task automatic pixel(input logic [9:0] h, input logic [9:0] v, input bit chk_ta,
                       input logic [7:0] ta, input logic [7:0] col, input string nm);
    @(negedge clk);
    h_count = h;
    v_count = v;
    @(posedge clk); #1;
    h_count = 10'd100;
    v_count = 10'd100;
    @(posedge clk); #1;
    if (chk_ta) chk({nm, " tex_addr"}, tex_addr, ta);
    @(posedge clk);
    @(posedge clk); #1;
    chk({nm, " color"}, color, col);
  endtask

  task automatic write_cell(input logic [8:0] a, input logic [1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      anim_tick = 1'b1;
      @(posedge clk); #1;
      anim_tick = 1'b0;
    end
  endtask

  task automatic latch_scroll(input logic [9:0] sx, input logic [9:0] sy);
    @(negedge clk);
    scroll_x = sx;
    scroll_y = sy;
    h_count  = 10'd0;
    v_count  = 10'd0;
    @(posedge clk); #1;
    h_count = 10'd100;
    v_count = 10'd100;
  endtask

  task automatic pulse_clear(output int t);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    t = cyc;
  endtask

  task automatic wait_sweep(input int start, input string nm);
    int   n;
    logic prev_rdy;
    n = 0;
    prev_rdy = wr_ready;
    while (busy && n < 1000) begin
      prev_rdy = wr_ready;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " busy_cycles"}, cyc - start, 300);
    chk({nm, " wr_ready_before"}, prev_rdy, 1'b0);
    chk({nm, " wr_ready_after"}, wr_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{10'd144, 10'd31,  1'b1, 8'h40, rom_f(8'h40), "cell0"};
    vecs[1]  = '{10'd176, 10'd63,  1'b1, 8'h00, rom_f(8'h00), "cell21"};
    vecs[2]  = '{10'd752, 10'd479, 1'b1, 8'h40, rom_f(8'h40), "cell299"};
    vecs[3]  = '{10'd147, 10'd36,  1'b1, 8'h6B, rom_f(8'h6B), "texel_3_5"};
    vecs[4]  = '{10'd783, 10'd31,  1'b1, 8'h47, rom_f(8'h47), "last_col"};
    vecs[5]  = '{10'd176, 10'd510, 1'b1, 8'h78, rom_f(8'h78), "last_line"};
    vecs[6]  = '{10'd100, 10'd100, 1'b0, 8'h00, 8'h00,        "h100"};
    vecs[7]  = '{10'd784, 10'd31,  1'b0, 8'h00, 8'h00,        "h784"};
    vecs[8]  = '{10'd176, 10'd511, 1'b0, 8'h00, 8'h00,        "v511"};
    vecs[9]  = '{10'd176, 10'd520, 1'b0, 8'h00, 8'h00,        "v520"};
    vecs[10] = '{10'd143, 10'd31,  1'b0, 8'h00, 8'h00,        "h143"};
    vecs[11] = '{10'd144, 10'd30,  1'b0, 8'h00, 8'h00,        "v30"};

    rst_n = 1'b1;
    h_count = 10'd100; v_count = 10'd100;
    scroll_x = '0; scroll_y = '0;
    anim_tick = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst color", color, 8'h00);
    chk("rst tex_addr", tex_addr, 8'h00);
    chk("rst busy", busy, 1'b1);
    chk("rst wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_sweep(t0, "init");

    foreach (vecs[i]) pixel(vecs[i].h, vecs[i].v, vecs[i].chk_ta, vecs[i].ta, vecs[i].col, vecs[i].nm);

    write_cell(9'd21, 2'd2);
    pixel(10'd176, 10'd63, 1'b1, 8'h80, 8'hA5, "run_write");

    // Same-clock write and read of cell 22: old tile first, new tile next read
    @(negedge clk);
    h_count = 10'd208; v_count = 10'd63;
    @(posedge clk); #1;
    h_count = 10'd100; v_count = 10'd100;
    wr_en = 1'b1; wr_addr = 9'd22; wr_data = 2'd3;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("rw_same old tex_addr", tex_addr, 8'h00);
    pixel(10'd208, 10'd63, 1'b1, 8'hC0, rom_f(8'hC0), "rw_same new");

    // Animation phase is the counter MSB
    tick(7);
    pixel(10'd146, 10'd31, 1'b1, 8'h42, rom_f(8'h42), "anim7");
    tick(1);
    pixel(10'd146, 10'd31, 1'b1, 8'h45, rom_f(8'h45), "anim8 type1");
    pixel(10'd242, 10'd63, 1'b1, 8'h02, rom_f(8'h02), "anim8 type0");
    pixel(10'd178, 10'd63, 1'b1, 8'h85, rom_f(8'h85), "anim8 type2");
    tick(8);
    pixel(10'd146, 10'd31, 1'b1, 8'h42, rom_f(8'h42), "anim16 wrap");

    // Scroll wrap and frame-start latching
    write_cell(9'd19, 2'd3);
    latch_scroll(10'd630, 10'd0);
    pixel(10'd144, 10'd31, 1'b1, 8'hC6, rom_f(8'hC6), "scroll col19");
    pixel(10'd154, 10'd31, 1'b1, 8'h40, rom_f(8'h40), "scroll wrap col0");
    scroll_x = 10'd0;
    pixel(10'd144, 10'd31, 1'b1, 8'hC6, rom_f(8'hC6), "scroll no_tear");
    latch_scroll(10'd0, 10'd470);
    pixel(10'd176, 10'd31, 1'b1, 8'h70, rom_f(8'h70), "scroll_y row14");
    pixel(10'd176, 10'd41, 1'b1, 8'h40, rom_f(8'h40), "scroll_y wrap");
    latch_scroll(10'd0, 10'd0);

    // Clear beats a same-clock write; clear during CLEAR restarts; writes in CLEAR are dropped
    @(negedge clk);
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 9'd21; wr_data = 2'd3;
    @(posedge clk); #1;
    clear_req = 1'b0; wr_en = 1'b0;
    chk("clear_enter busy", busy, 1'b1);
    chk("clear_enter wr_ready", wr_ready, 1'b0);
    repeat (100) @(posedge clk);
    pulse_clear(t0);
    repeat (100) @(posedge clk);
    write_cell(9'd21, 2'd3);
    write_cell(9'd0, 2'd2);
    pixel(10'd176, 10'd63, 1'b0, 8'h00, 8'h00, "clear_blank");
    wait_sweep(t0, "restart");
    pixel(10'd176, 10'd63, 1'b1, 8'h00, rom_f(8'h00), "clr cell21");
    pixel(10'd144, 10'd31, 1'b1, 8'h40, rom_f(8'h40), "clr cell0");
    pixel(10'd752, 10'd31, 1'b1, 8'h40, rom_f(8'h40), "clr cell19");
    pixel(10'd208, 10'd63, 1'b1, 8'h00, rom_f(8'h00), "clr cell22");

    // Reset in the middle of a sweep
    latch_scroll(10'd630, 10'd0);
    tick(8);
    pulse_clear(t0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", busy, 1'b1);
    chk("rst_mid wr_ready", wr_ready, 1'b0);
    chk("rst_mid tex_addr", tex_addr, 8'h00);
    chk("rst_mid color", color, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_sweep(t0, "rst_mid");
    pixel(10'd146, 10'd31, 1'b1, 8'h42, rom_f(8'h42), "rst_mid anim_scroll");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
